mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits directly upstream of the main-memory model, between the two cache controllers (icache, dcache) and the memory request/response port.
- Arbitrates line-fill reads from both caches and dirty-line writebacks from the dcache.
- Emulates a fixed memory access latency and serialises traffic to one outstanding operation.
- Routes each returned cacheline back to the client that requested it.

Parameters:
- LATENCY, 5, cycles from grant to memory request issue; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_req  in  1  icache read request, level; held until ic_rsp
- ic_addr  in  $bits(pptr_t)  icache line address
- ic_rsp  out  1  one-cycle pulse: ic_line valid
- ic_line  out  $bits(cacheline_t)  returned line for icache
- dc_req  in  1  dcache read request, level; held until dc_rsp
- dc_addr  in  $bits(pptr_t)  dcache read line address
- dc_rsp  out  1  one-cycle pulse: dc_line valid
- dc_line  out  $bits(cacheline_t)  returned line for dcache
- dc_wb  in  1  dcache writeback request, level; held until dc_wb_ack
- dc_wb_addr  in  $bits(pptr_t)  writeback address
- dc_wb_line  in  $bits(cacheline_t)  writeback data
- dc_wb_ack  out  1  one-cycle pulse: writeback committed
- mem_ren  out  1  memory read request pulse
- mem_raddr  out  $bits(pptr_t)  memory read address
- mem_wen  out  1  memory write request pulse
- mem_waddr  out  $bits(pptr_t)  memory write address
- mem_wline  out  $bits(cacheline_t)  memory write data
- mem_rec_en  in  1  memory response valid (one cycle after mem_ren)
- mem_rec_addr  in  $bits(pptr_t)  response address
- mem_rec_line  in  $bits(cacheline_t)  response data

Behaviour:
- All outputs are registered. Reset values: every pulse/enable output 0, all address/data outputs 0, state IDLE, counter 0, round-robin pointer = icache.
- FSM states: IDLE, DELAY, ISSUE, WAIT, RESP.
- IDLE:
  - Samples requests. Fixed priority: dc_wb > dc_req > ic_req.
  - On grant in cycle T: latch the source (IC_RD, DC_RD or DC_WB), address, and data for writebacks. Counter <= LATENCY-1. Next state is ISSUE if LATENCY==1, otherwise DELAY.
- DELAY:
  - Decrement counter each cycle. Move to ISSUE when counter reaches 1.
  - Request inputs are ignored; the latched values are used.
- ISSUE (cycle T+LATENCY):
  - Read: mem_ren=1 and mem_raddr=latched address for exactly this cycle; next state WAIT.
  - Write: mem_wen=1, mem_waddr/mem_wline=latched values, and dc_wb_ack=1 in the same cycle; next state IDLE.
- WAIT:
  - On mem_rec_en: capture mem_rec_line into ic_line or dc_line according to the latched source, and pulse the matching ic_rsp/dc_rsp in the next cycle (T+LATENCY+2). Next state RESP.
  - The unselected client's line output holds its previous value.
- RESP: rsp pulse is visible; next state IDLE. IDLE is re-entered at T+LATENCY+3.
  - This guarantees the client has dropped its req before re-arbitration, so the same request is never re-granted.
- Read latency: ic_rsp/dc_rsp at T+LATENCY+2. Write latency: dc_wb_ack at T+LATENCY.
- Address check: mem_rec_addr is compared with the latched address. On mismatch the response is still forwarded; see the optional feature.
- mem_rec_en seen in any state other than WAIT is ignored.
- Simultaneous requests in IDLE: exactly one is granted; the others wait, since requests are level-held.
- Only one operation is ever outstanding. mem_ren and mem_wen are never asserted in the same cycle.
- rst mid-operation: return to IDLE on the next edge, clear all pulses, drop the latched operation. A late mem_rec_en after reset is ignored.

Optional Feature:
- MEM_ARB_ROUNDROBIN_EN defined:
  - Reads alternate between icache and dcache. The pointer flips to the other client after each granted read; dc_wb still has top priority.
  - A sticky output arb_err (1 bit, reset 0) is added. It sets when, in WAIT, mem_rec_en arrives with mem_rec_addr != latched address.
- Not defined: fixed priority dc_wb > dc_req > ic_req, and no arb_err port.

Test Plan:
- LATENCY=5; ic_req=1, ic_addr=0x0000_1040 at cycle 0 -> mem_ren=1, mem_raddr=0x0000_1040 at cycle 5; memory returns line L at 6; ic_rsp=1, ic_line=L at 7; idle at 8.
- dc_wb (addr 0x200, line W) and dc_req (addr 0x300) both raised at cycle 0 -> mem_wen, mem_waddr=0x200, mem_wline=W, dc_wb_ack at cycle 5; then dc_req granted at 6, mem_ren at 11, dc_rsp at 13.
- ic_req and dc_req raised together at cycle 0, fixed priority -> dc_rsp at 7, then ic granted at 8, ic_rsp at 15. With MEM_ARB_ROUNDROBIN_EN, the first grant goes to icache.
- LATENCY=1; dc_req at cycle 0 -> mem_ren at 1, dc_rsp at 3; back-to-back second dc_req granted at cycle 4.
- rst asserted at cycle 3 during DELAY of an ic read -> no mem_ren issued, all outputs 0 at cycle 4; injected mem_rec_en at 6 yields no ic_rsp.
- MEM_ARB_ROUNDROBIN_EN; memory returns mem_rec_addr=0x444 for a read of 0x440 -> response still forwarded and arb_err=1, staying set until rst.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Brief    : Client (icache/dcache) and main-memory signal bundle for
//             mem_arbiter. arb_err exists only with MEM_ARB_ROUNDROBIN_EN.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    typedef logic [ADDR_W-1:0] pptr_t;
    typedef logic [LINE_W-1:0] cacheline_t;

    logic       ic_req;
    pptr_t      ic_addr;
    logic       ic_rsp;
    cacheline_t ic_line;

    logic       dc_req;
    pptr_t      dc_addr;
    logic       dc_rsp;
    cacheline_t dc_line;

    logic       dc_wb;
    pptr_t      dc_wb_addr;
    cacheline_t dc_wb_line;
    logic       dc_wb_ack;

    logic       mem_ren;
    pptr_t      mem_raddr;
    logic       mem_wen;
    pptr_t      mem_waddr;
    cacheline_t mem_wline;
    logic       mem_rec_en;
    pptr_t      mem_rec_addr;
    cacheline_t mem_rec_line;

`ifdef MEM_ARB_ROUNDROBIN_EN
    logic       arb_err;
`endif

    // Arbiter side
    modport slave (
        input  ic_req, ic_addr, dc_req, dc_addr, dc_wb, dc_wb_addr, dc_wb_line,
        input  mem_rec_en, mem_rec_addr, mem_rec_line,
`ifdef MEM_ARB_ROUNDROBIN_EN
        output arb_err,
`endif
        output ic_rsp, ic_line, dc_rsp, dc_line, dc_wb_ack,
        output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wline
    );

    // Environment side: caches plus memory model
    modport master (
        output ic_req, ic_addr, dc_req, dc_addr, dc_wb, dc_wb_addr, dc_wb_line,
        output mem_rec_en, mem_rec_addr, mem_rec_line,
`ifdef MEM_ARB_ROUNDROBIN_EN
        input  arb_err,
`endif
        input  ic_rsp, ic_line, dc_rsp, dc_line, dc_wb_ack,
        input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wline
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Serialises icache/dcache line fills and dcache writebacks onto
//             one memory port with a fixed LATENCY-cycle issue delay.
//             Define MEM_ARB_ROUNDROBIN_EN for alternating read grants and
//             the sticky arb_err response-address check.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LATENCY = 5,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DELAY = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] C_SRC_IC_RD = 2'd0;
    localparam logic [1:0] C_SRC_DC_RD = 2'd1;
    localparam logic [1:0] C_SRC_DC_WB = 2'd2;

    localparam logic [7:0] C_CNT_INIT = 8'(LATENCY - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [7:0]        r_cnt;
    logic [1:0]        r_src;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wb_line;

    logic              r_mem_ren;
    logic [ADDR_W-1:0] r_mem_raddr;
    logic              r_mem_wen;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [LINE_W-1:0] r_mem_wline;
    logic              r_dc_wb_ack;
    logic              r_ic_rsp;
    logic [LINE_W-1:0] r_ic_line;
    logic              r_dc_rsp;
    logic [LINE_W-1:0] r_dc_line;

    logic              w_grant;
    logic [1:0]        w_grant_src;
    logic [ADDR_W-1:0] w_grant_addr;
    logic              w_dc_wins;
    logic [1:0]        w_op_src;
    logic [ADDR_W-1:0] w_op_addr;
    logic [LINE_W-1:0] w_op_wline;
    logic              w_issue;
    logic              w_capture;

`ifdef MEM_ARB_ROUNDROBIN_EN
    localparam logic C_PTR_IC = 1'b0;
    localparam logic C_PTR_DC = 1'b1;

    logic r_rr_ptr;
    logic r_arb_err;

    // Contended reads go to whichever client the pointer names
    assign w_dc_wins = bus.dc_req && !(bus.ic_req && (r_rr_ptr == C_PTR_IC));
`else
    assign w_dc_wins = bus.dc_req;
`endif

    always_comb begin
        w_grant      = 1'b0;
        w_grant_src  = C_SRC_IC_RD;
        w_grant_addr = bus.ic_addr;
        if (bus.dc_wb) begin
            w_grant      = 1'b1;
            w_grant_src  = C_SRC_DC_WB;
            w_grant_addr = bus.dc_wb_addr;
        end else if (w_dc_wins) begin
            w_grant      = 1'b1;
            w_grant_src  = C_SRC_DC_RD;
            w_grant_addr = bus.dc_addr;
        end else if (bus.ic_req) begin
            w_grant      = 1'b1;
            w_grant_src  = C_SRC_IC_RD;
            w_grant_addr = bus.ic_addr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next_state = (LATENCY == 1) ? S_ISSUE : S_DELAY;
            S_DELAY: if (r_cnt == 8'd1) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = (r_src == C_SRC_DC_WB) ? S_IDLE : S_WAIT;
            S_WAIT:  if (bus.mem_rec_en) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // With LATENCY==1 the issue is decided in IDLE, before the grant is latched
    assign w_op_src   = (r_state == S_IDLE) ? w_grant_src  : r_src;
    assign w_op_addr  = (r_state == S_IDLE) ? w_grant_addr : r_addr;
    assign w_op_wline = (r_state == S_IDLE) ? bus.dc_wb_line : r_wb_line;
    assign w_issue    = (w_next_state == S_ISSUE) && (r_state != S_ISSUE);
    assign w_capture  = (r_state == S_WAIT) && bus.mem_rec_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_src       <= C_SRC_IC_RD;
            r_addr      <= '0;
            r_wb_line   <= '0;
            r_mem_ren   <= 1'b0;
            r_mem_raddr <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wline <= '0;
            r_dc_wb_ack <= 1'b0;
            r_ic_rsp    <= 1'b0;
            r_ic_line   <= '0;
            r_dc_rsp    <= 1'b0;
            r_dc_line   <= '0;
`ifdef MEM_ARB_ROUNDROBIN_EN
            r_rr_ptr    <= C_PTR_IC;
            r_arb_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_mem_ren   <= w_issue && (w_op_src != C_SRC_DC_WB);
            r_mem_wen   <= w_issue && (w_op_src == C_SRC_DC_WB);
            r_dc_wb_ack <= w_issue && (w_op_src == C_SRC_DC_WB);
            r_ic_rsp    <= w_capture && (r_src == C_SRC_IC_RD);
            r_dc_rsp    <= w_capture && (r_src == C_SRC_DC_RD);

            if (w_issue && (w_op_src != C_SRC_DC_WB)) begin
                r_mem_raddr <= w_op_addr;
            end
            if (w_issue && (w_op_src == C_SRC_DC_WB)) begin
                r_mem_waddr <= w_op_addr;
                r_mem_wline <= w_op_wline;
            end

            if ((r_state == S_IDLE) && w_grant) begin
                r_src  <= w_grant_src;
                r_addr <= w_grant_addr;
                r_cnt  <= C_CNT_INIT;
                if (w_grant_src == C_SRC_DC_WB) begin
                    r_wb_line <= bus.dc_wb_line;
                end
`ifdef MEM_ARB_ROUNDROBIN_EN
                if (w_grant_src == C_SRC_IC_RD) r_rr_ptr <= C_PTR_DC;
                if (w_grant_src == C_SRC_DC_RD) r_rr_ptr <= C_PTR_IC;
`endif
            end else if (r_state == S_DELAY) begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (w_capture && (r_src == C_SRC_IC_RD)) r_ic_line <= bus.mem_rec_line;
            if (w_capture && (r_src == C_SRC_DC_RD)) r_dc_line <= bus.mem_rec_line;
`ifdef MEM_ARB_ROUNDROBIN_EN
            if (w_capture && (bus.mem_rec_addr != r_addr)) r_arb_err <= 1'b1;
`endif
        end
    end

    assign bus.mem_ren   = r_mem_ren;
    assign bus.mem_raddr = r_mem_raddr;
    assign bus.mem_wen   = r_mem_wen;
    assign bus.mem_waddr = r_mem_waddr;
    assign bus.mem_wline = r_mem_wline;
    assign bus.dc_wb_ack = r_dc_wb_ack;
    assign bus.ic_rsp    = r_ic_rsp;
    assign bus.ic_line   = r_ic_line;
    assign bus.dc_rsp    = r_dc_rsp;
    assign bus.dc_line   = r_dc_line;
`ifdef MEM_ARB_ROUNDROBIN_EN
    assign bus.arb_err   = r_arb_err;
`endif
endmodule
`default_nettype wire
